// File: rtl/fft_frame_feeder_if.sv
// Streaming sink bus between the frame feeder and the FFT core input.
// The feeder drives beats as master; the FFT core is the slave and returns ready.
interface fft_frame_feeder_if #(
    parameter int DATA_W = 24
);
    logic              sink_valid;
    logic              sink_ready;
    logic              sink_sop;
    logic              sink_eop;
    logic [DATA_W-1:0] sink_real;
    logic [DATA_W-1:0] sink_imag;
    logic [1:0]        sink_error;
    logic              inverse;

    modport master (
        output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, inverse,
        input  sink_ready
    );

    modport slave (
        input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, inverse,
        output sink_ready
    );
endinterface

// File: rtl/fft_frame_feeder.sv
// Ping-pong frame buffer: audio samples fill one bank while the other bank streams
// to the FFT sink as one sop..eop packet, with a skid stage so ready stalls never lose beats.
module fft_frame_feeder #(
    parameter int FFT_LEN = 1024,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_data,
    fft_frame_feeder_if.master       sink,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic                     busy
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FFT_LEN - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_reg, state_next;

    logic [1:0]        full_reg;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_bank_reg;
    logic              rd_bank_reg;
    logic [ADDR_W-1:0] wr_idx_reg;
    logic [ADDR_W-1:0] rd_idx_reg;
    logic              more_reg;
    logic              overflow_reg;

    logic [DATA_W-1:0] mem [0:2*FFT_LEN-1];

    // Pipeline: RAM read register -> output register, with a one-entry skid behind it
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_vld_reg, rd_sop_reg, rd_eop_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic              skid_vld_reg, skid_sop_reg, skid_eop_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_vld_reg, out_sop_reg, out_eop_reg;

    logic              wr_en, wr_done, drop;
    logic              pop, eop_xfer, out_free;
    logic              issue, issue_last;
    logic [1:0]        occ_after;

    assign wr_en    = sample_valid & ~full_reg[wr_bank_reg];
    assign drop     = sample_valid &  full_reg[wr_bank_reg];
    assign wr_done  = wr_en & (wr_idx_reg == LAST_IDX);
    assign pop      = out_vld_reg & sink.sink_ready;
    assign eop_xfer = pop & out_eop_reg;
    assign out_free = ~out_vld_reg | pop;

    // Entries still held after this cycle's pop; a new read is allowed only if one slot stays free
    assign occ_after  = {1'b0, out_vld_reg} + {1'b0, skid_vld_reg} + {1'b0, rd_vld_reg} - {1'b0, pop};
    assign issue_last = issue & (rd_idx_reg == LAST_IDX);

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (full_reg[rd_bank_reg]) begin
                    state_next = STREAM;
                    issue      = 1'b1;
                end
            end
            STREAM: begin
                issue = more_reg && (occ_after <= 2'd1);
                if (eop_xfer) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Write and read completions always hit different banks, so set and clear never collide
    for (genvar gi = 0; gi < 2; gi++) begin : g_full
        assign full_set[gi] = wr_done  & (wr_bank_reg == 1'(gi));
        assign full_clr[gi] = eop_xfer & (rd_bank_reg == 1'(gi));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                full_reg[gi] <= 1'b0;
            end else begin
                full_reg[gi] <= full_set[gi] | (full_reg[gi] & ~full_clr[gi]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank_reg, wr_idx_reg}] <= sample_data;
        end
        if (issue) begin
            rd_data_reg <= mem[{rd_bank_reg, rd_idx_reg}];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_reg  <= 1'b0;
            rd_bank_reg  <= 1'b0;
            wr_idx_reg   <= '0;
            rd_idx_reg   <= '0;
            more_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            rd_vld_reg   <= 1'b0;
            rd_sop_reg   <= 1'b0;
            rd_eop_reg   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_idx_reg <= wr_idx_reg + 1'b1;
            end
            if (wr_done) begin
                wr_bank_reg <= ~wr_bank_reg;
            end
            if (eop_xfer) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
            if (issue) begin
                rd_idx_reg <= rd_idx_reg + 1'b1;
            end
            if (issue && state_reg == IDLE) begin
                more_reg <= 1'b1;
            end else if (issue_last) begin
                more_reg <= 1'b0;
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clear_overflow) begin
                overflow_reg <= 1'b0;
            end
            rd_vld_reg <= issue;
            rd_sop_reg <= issue & (rd_idx_reg == '0);
            rd_eop_reg <= issue_last;
        end
    end

    // Skid holds a read that arrived while the output was stalled; it always drains first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_vld_reg   <= 1'b0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
            out_data_reg  <= '0;
            skid_vld_reg  <= 1'b0;
            skid_sop_reg  <= 1'b0;
            skid_eop_reg  <= 1'b0;
            skid_data_reg <= '0;
        end else if (out_free) begin
            if (skid_vld_reg) begin
                out_vld_reg  <= 1'b1;
                out_sop_reg  <= skid_sop_reg;
                out_eop_reg  <= skid_eop_reg;
                out_data_reg <= skid_data_reg;
                skid_vld_reg <= rd_vld_reg;
                if (rd_vld_reg) begin
                    skid_sop_reg  <= rd_sop_reg;
                    skid_eop_reg  <= rd_eop_reg;
                    skid_data_reg <= rd_data_reg;
                end
            end else begin
                out_vld_reg <= rd_vld_reg;
                out_sop_reg <= rd_vld_reg & rd_sop_reg;
                out_eop_reg <= rd_vld_reg & rd_eop_reg;
                if (rd_vld_reg) begin
                    out_data_reg <= rd_data_reg;
                end
            end
        end else if (rd_vld_reg) begin
            skid_vld_reg  <= 1'b1;
            skid_sop_reg  <= rd_sop_reg;
            skid_eop_reg  <= rd_eop_reg;
            skid_data_reg <= rd_data_reg;
        end
    end

    assign sink.sink_valid = out_vld_reg;
    assign sink.sink_sop   = out_sop_reg;
    assign sink.sink_eop   = out_eop_reg;
    assign sink.sink_real  = out_data_reg;
    assign sink.sink_imag  = '0;
    assign sink.sink_error = 2'b00;
    assign sink.inverse    = 1'b0;
    assign overflow        = overflow_reg;
    assign busy            = (state_reg == STREAM);
endmodule
